multilane_shift_serdes_parameter: RTL and testbench
===================================================

Name: multilane_shift_serdes_parameter

Overview:
- Parametrised full-duplex shift engine; successor to the single-bit shift and scan registers.
- Accepts a parallel word over a valid/ready handshake, then shifts it out on LANES serial lines over WIDTH/LANES beats.
- Captures the same number of bits from LANES serial inputs, and returns the received word over a second valid/ready handshake.
- Used as the core of SPI-like links and wide scan-chain drivers.

Parameters:
- width, 8: word width in bits; must be ≥2 and a multiple of lanes.
- lanes, 1: serial lanes moved per beat; 1 ≤ lanes ≤ width.
- Derived beats = width/lanes; counter width = max(1, $clog2(beats)).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  parallel word offered
- in_ready  output  1  block can accept a word
- in_data  input  width  word to transmit
- lsb_first  input  1  bit order; sampled with in_data on accept
- stall  input  1  pauses shifting while high
- sin  input  lanes  serial receive data
- sout  output  lanes  serial transmit data
- sout_valid  output  1  sout and sin meaningful this cycle (beat in progress)
- out_valid  output  1  received word available
- out_ready  input  1  consumer accepts received word
- out_data  output  width  received word
- busy  output  1  state ≠ IDLE

Behaviour:
States: IDLE, SHIFT, HOLD. Internal registers: sreg[width], beat counter, order flag.
- Reset (synchronous, priority over all): state = IDLE, sreg = 0, counter = 0, order flag = 0; all outputs 0 except in_ready = 1.
  - Reset asserted mid-SHIFT or in HOLD aborts the word; the partial word is discarded, with no out_valid.

IDLE:
- in_ready = 1.
- On in_valid at an edge: sreg ← in_data, order flag ← lsb_first, counter ← 0, go to SHIFT.

SHIFT:
- in_ready = 0; sout_valid = !stall.
- sout:
  - MSB-first: sout = sreg[width-1 -: lanes].
  - LSB-first: sout = sreg[lanes-1:0].
  - Lane i carries bit i of the slice.
- At each edge with !stall:
  - MSB-first: sreg ← {sreg[width-lanes-1:0], sin}.
  - LSB-first: sreg ← {sin, sreg[width-1:lanes]}.
  - counter increments.
- On the edge where counter == beats-1 and !stall, go to HOLD.
- Stall high: sreg, counter and sout are held and sin is ignored; stall in IDLE or HOLD has no effect.
- Latency: out_valid rises exactly beats+S cycles after the accepting edge, where S is the number of stalled SHIFT cycles.
- sout is a registered-output slice; no combinational path from sin to sout.
- in_valid and in_ready are ignored in SHIFT.

HOLD:
- out_valid = 1; out_data = sreg (stable until handshake); in_ready = out_ready.
- out_valid && out_ready with in_valid: load the new word, go directly to SHIFT (back-to-back, no idle bubble).
- out_valid && out_ready without in_valid: go to IDLE.
- out_data reads 0 whenever out_valid = 0 (gated).

Boundaries:
- lanes == width: beats = 1, so one shift edge, then HOLD.
- out_ready held low keeps HOLD indefinitely; no data loss, no new accept.
- sout = 0 and sout_valid = 0 outside SHIFT.

Optional Feature:
- Macro SERDES_LOOPBACK_EN.
- Defined:
  - Adds input loopback (1 bit); when high, the internal receive path uses sout instead of the sin port.
  - After a full transfer, out_data equals the transmitted word rotated into place, i.e. out_data == in_data for either bit order.
  - sout is still driven externally.
- Undefined: no loopback port; the receive path is always sin.

Test Plan:
- width=8, lanes=1, in_data=0xA5, lsb_first=0, sin stream 0,0,1,1,1,1,0,0 -> sout 1,0,1,0,0,1,0,1 over 8 beats; out_valid 8 cycles after accept; out_data=0x3C.
- width=8, lanes=2, in_data=0xA5, lsb_first=1, sin=2'b11 every beat -> sout 01,01,10,10 over 4 beats; out_data=0xFF; busy high for 4 SHIFT cycles plus HOLD.
- width=8, lanes=1, stall high for 3 cycles after beat 2 -> sout held on bit 5 value for 3 cycles, sout_valid=0 during stall; out_valid at cycle 11; out_data unchanged vs. no-stall run.
- HOLD with out_ready=0 for 5 cycles, then out_ready=1 with in_valid=1, in_data=0x5A -> out_data stable for 5 cycles; same-edge handshake on both sides; next cycle SHIFT with sout=0 (MSB of 0x5A), no idle cycle.
- Reset asserted at beat 4 of a transfer -> next cycle IDLE, in_ready=1, out_valid=0, sout=0; a subsequent transfer of 0xC3 completes correctly.
- SERDES_LOOPBACK_EN, loopback=1, width=16, lanes=4, in_data=0xBEEF, either order -> out_data=0xBEEF after 4 beats.

Source files
------------

// File: rtl/multilane_shift_serdes_parameter.sv
// Multi-lane full-duplex shift engine: parallel word in, width/lanes serial beats out and in, parallel word back.
// Optional SERDES_LOOPBACK_EN adds a loopback input that feeds sout back into the receive path.
module multilane_shift_serdes_parameter #(
    parameter int width = 8,
    parameter int lanes = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_data,
    input  logic             lsb_first,
    input  logic             stall,
    input  logic [lanes-1:0] sin,
`ifdef SERDES_LOOPBACK_EN
    input  logic             loopback,
`endif
    output logic [lanes-1:0] sout,
    output logic             sout_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_data,
    output logic             busy
);

    localparam int beats = width / lanes;
    localparam int cw    = (beats > 1) ? $clog2(beats) : 1;
    localparam logic [cw-1:0] last_beat = cw'(beats - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    logic [width-1:0] sreg;
    logic [cw-1:0]    beat_cnt;
    logic             order_lsb;

    logic [lanes-1:0] tx_slice;
    logic [lanes-1:0] rx_slice;
    logic [width-1:0] sreg_shifted;

    assign tx_slice = order_lsb ? sreg[lanes-1:0] : sreg[width-1 -: lanes];

`ifdef SERDES_LOOPBACK_EN
    assign rx_slice = loopback ? tx_slice : sin;
`else
    assign rx_slice = sin;
`endif

    // A single-beat word is replaced outright; slicing below would go out of range.
    generate
        if (lanes == width) begin : g_single_beat
            assign sreg_shifted = rx_slice;
        end else begin : g_multi_beat
            assign sreg_shifted = order_lsb ? {rx_slice, sreg[width-1:lanes]}
                                            : {sreg[width-lanes-1:0], rx_slice};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sreg      <= '0;
            beat_cnt  <= '0;
            order_lsb <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sreg      <= in_data;
                        order_lsb <= lsb_first;
                        beat_cnt  <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!stall) begin
                        sreg     <= sreg_shifted;
                        beat_cnt <= beat_cnt + cw'(1);
                        if (beat_cnt == last_beat) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // Reloading straight from HOLD avoids an idle bubble between words.
                    if (out_ready) begin
                        if (in_valid) begin
                            sreg      <= in_data;
                            order_lsb <= lsb_first;
                            beat_cnt  <= '0;
                            state     <= SHIFT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        in_ready   = 1'b0;
        sout       = '0;
        sout_valid = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
            end
            SHIFT: begin
                sout       = tx_slice;
                sout_valid = !stall;
            end
            HOLD: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
                out_data  = sreg;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multilane_shift_serdes_parameter.sv
// Directed bench for multilane_shift_serdes_parameter: 8x1, 8x2 and 4x4 instances, loopback 16x4 when enabled.
module tb_multilane_shift_serdes_parameter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       lsb_first = 1'b0;
    logic       stall = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic       a_in_valid = 1'b0;
    logic       a_in_ready;
    logic [0:0] a_sin = 1'b0;
    logic [0:0] a_sout;
    logic       a_sout_valid, a_out_valid, a_busy;
    logic [7:0] a_out_data;

    logic       b_in_valid = 1'b0;
    logic       b_in_ready;
    logic [1:0] b_sin = 2'b00;
    logic [1:0] b_sout;
    logic       b_sout_valid, b_out_valid, b_busy;
    logic [7:0] b_out_data;

    logic       c_in_valid = 1'b0;
    logic       c_in_ready;
    logic [3:0] c_in_data = 4'h0;
    logic [3:0] c_sin = 4'h0;
    logic [3:0] c_sout;
    logic       c_sout_valid, c_out_valid, c_busy;
    logic [3:0] c_out_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multilane_shift_serdes_parameter #(.width(8), .lanes(1)) u_a (
        .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .lsb_first(lsb_first), .stall(stall), .sin(a_sin),
`ifdef SERDES_LOOPBACK_EN
        .loopback(1'b0),
`endif
        .sout(a_sout), .sout_valid(a_sout_valid), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_data(a_out_data), .busy(a_busy)
    );

    multilane_shift_serdes_parameter #(.width(8), .lanes(2)) u_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .lsb_first(lsb_first), .stall(stall), .sin(b_sin),
`ifdef SERDES_LOOPBACK_EN
        .loopback(1'b0),
`endif
        .sout(b_sout), .sout_valid(b_sout_valid), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_data(b_out_data), .busy(b_busy)
    );

    multilane_shift_serdes_parameter #(.width(4), .lanes(4)) u_c (
        .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .lsb_first(lsb_first), .stall(stall), .sin(c_sin),
`ifdef SERDES_LOOPBACK_EN
        .loopback(1'b0),
`endif
        .sout(c_sout), .sout_valid(c_sout_valid), .out_valid(c_out_valid),
        .out_ready(out_ready), .out_data(c_out_data), .busy(c_busy)
    );

`ifdef SERDES_LOOPBACK_EN
    logic        d_in_valid = 1'b0;
    logic        d_in_ready;
    logic [15:0] d_in_data = 16'h0;
    logic [3:0]  d_sout;
    logic        d_sout_valid, d_out_valid, d_busy;
    logic [15:0] d_out_data;

    multilane_shift_serdes_parameter #(.width(16), .lanes(4)) u_d (
        .clk(clk), .reset(reset), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_data(d_in_data), .lsb_first(lsb_first), .stall(stall), .sin(4'h0),
        .loopback(1'b1),
        .sout(d_sout), .sout_valid(d_sout_valid), .out_valid(d_out_valid),
        .out_ready(out_ready), .out_data(d_out_data), .busy(d_busy)
    );
`endif

    // Full 8x1 transfer: rx bits are presented so the received word equals rx.
    task automatic xfer_a(input logic [7:0] tx, input logic lsb, input logic [7:0] rx, input string tag);
        a_in_valid = 1'b1;
        in_data    = tx;
        lsb_first  = lsb;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            #1;
            a_in_valid = 1'b0;
            a_sin      = lsb ? rx[k] : rx[7-k];
            #1;
            checks++;
            if (a_sout[0] !== (lsb ? tx[k] : tx[7-k])) begin
                errors++;
                $display("FAIL %s sout beat %0d: got %b expected %b", tag, k, a_sout[0], lsb ? tx[k] : tx[7-k]);
            end
            checks++;
            if (a_sout_valid !== 1'b1 || a_out_valid !== 1'b0 || a_in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s flags beat %0d: got sv=%b ov=%b ir=%b expected 1 0 0", tag, k, a_sout_valid, a_out_valid, a_in_ready);
            end
            @(posedge clk);
        end
        #2;
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== rx) begin
            errors++;
            $display("FAIL %s result: got ov=%b data=%h expected 1 %h", tag, a_out_valid, a_out_data, rx);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s hold in_ready: got %b expected 1", tag, a_in_ready);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_out_data !== 8'h00 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s idle: got ov=%b busy=%b data=%h ir=%b expected 0 0 00 1", tag, a_out_valid, a_busy, a_out_data, a_in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_sout !== 1'b0 || a_sout_valid !== 1'b0 ||
            a_busy !== 1'b0 || a_out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_a: got ir=%b ov=%b sout=%b sv=%b busy=%b data=%h expected 1 0 0 0 0 00",
                     a_in_ready, a_out_valid, a_sout, a_sout_valid, a_busy, a_out_data);
        end
        checks++;
        if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_sout !== 2'b00 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_b: got ir=%b ov=%b sout=%b busy=%b expected 1 0 00 0", b_in_ready, b_out_valid, b_sout, b_busy);
        end
        reset = 1'b0;
    endtask

    task automatic test_msb_first();
        xfer_a(8'hA5, 1'b0, 8'h3C, "msb_a5");
    endtask

    task automatic test_lsb_first();
        xfer_a(8'h4D, 1'b1, 8'hB2, "lsb_4d");
    endtask

    task automatic test_two_lanes();
        logic [1:0] exp_sout [4] = '{2'b01, 2'b01, 2'b10, 2'b10};
        b_in_valid = 1'b1;
        in_data    = 8'hA5;
        lsb_first  = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            #1;
            b_in_valid = 1'b0;
            b_sin      = 2'b11;
            #1;
            checks++;
            if (b_sout !== exp_sout[k] || b_busy !== 1'b1 || b_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL lanes2 beat %0d: got sout=%b busy=%b ov=%b expected %b 1 0", k, b_sout, b_busy, b_out_valid, exp_sout[k]);
            end
            @(posedge clk);
        end
        #2;
        checks++;
        if (b_out_valid !== 1'b1 || b_out_data !== 8'hFF || b_busy !== 1'b1 || b_sout !== 2'b00) begin
            errors++;
            $display("FAIL lanes2 result: got ov=%b data=%h busy=%b sout=%b expected 1 ff 1 00", b_out_valid, b_out_data, b_busy, b_sout);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        #1;
        checks++;
        if (b_busy !== 1'b0 || b_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lanes2 idle: got busy=%b ov=%b expected 0 0", b_busy, b_out_valid);
        end
    endtask

    task automatic test_stall();
        logic [7:0] tx = 8'hA5;
        logic [7:0] rx = 8'h3C;
        int beat;
        a_in_valid = 1'b1;
        in_data    = tx;
        lsb_first  = 1'b0;
        @(posedge clk);
        for (int c = 0; c < 11; c++) begin
            beat = (c < 2) ? c : ((c < 5) ? 2 : c - 3);
            #1;
            a_in_valid = 1'b0;
            stall      = (c >= 2 && c < 5);
            a_sin      = stall ? ~rx[7-beat] : rx[7-beat];
            #1;
            checks++;
            if (a_sout[0] !== tx[7-beat] || a_sout_valid !== !stall || a_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall cycle %0d: got sout=%b sv=%b ov=%b expected %b %b 0", c, a_sout[0], a_sout_valid, a_out_valid, tx[7-beat], !stall);
            end
            @(posedge clk);
        end
        #2;
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== rx) begin
            errors++;
            $display("FAIL stall result: got ov=%b data=%h expected 1 %h", a_out_valid, a_out_data, rx);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] tx2 = 8'h5A;
        logic [7:0] rx2 = 8'h96;
        a_in_valid = 1'b1;
        in_data    = 8'h81;
        lsb_first  = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            #1;
            a_in_valid = 1'b0;
            a_sin      = 1'b1;
            @(posedge clk);
        end
        // Hold with consumer stalled while a new word is already offered.
        for (int h = 0; h < 5; h++) begin
            #1;
            a_in_valid = 1'b1;
            in_data    = tx2;
            stall      = 1'b1;
            #1;
            checks++;
            if (a_out_valid !== 1'b1 || a_out_data !== 8'hFF || a_in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold cycle %0d: got ov=%b data=%h ir=%b expected 1 ff 0", h, a_out_valid, a_out_data, a_in_ready);
            end
            @(posedge clk);
        end
        #1;
        stall     = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b handshake: got ir=%b ov=%b expected 1 1", a_in_ready, a_out_valid);
        end
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            #1;
            out_ready  = 1'b0;
            a_in_valid = 1'b0;
            a_sin      = rx2[7-k];
            #1;
            checks++;
            if (a_sout[0] !== tx2[7-k] || a_sout_valid !== 1'b1 || a_out_valid !== 1'b0 || a_busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b beat %0d: got sout=%b sv=%b ov=%b busy=%b expected %b 1 0 1", k, a_sout[0], a_sout_valid, a_out_valid, a_busy, tx2[7-k]);
            end
            @(posedge clk);
        end
        #2;
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== rx2) begin
            errors++;
            $display("FAIL b2b result: got ov=%b data=%h expected 1 %h", a_out_valid, a_out_data, rx2);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic seen_valid = 1'b0;
        a_in_valid = 1'b1;
        in_data    = 8'hFF;
        lsb_first  = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            #1;
            a_in_valid = 1'b0;
            a_sin      = 1'b1;
            @(posedge clk);
        end
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_sout !== 1'b0 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort state: got ir=%b ov=%b sout=%b busy=%b expected 1 0 0 0", a_in_ready, a_out_valid, a_sout, a_busy);
        end
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #2;
            if (a_out_valid !== 1'b0) seen_valid = 1'b1;
        end
        checks++;
        if (seen_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort no_out_valid: got %b expected 0", seen_valid);
        end
        xfer_a(8'hC3, 1'b0, 8'h3C, "after_abort");
    endtask

    task automatic test_full_width();
        logic [3:0] tx_v [2] = '{4'h9, 4'h3};
        logic [3:0] rx_v [2] = '{4'h6, 4'hC};
        for (int t = 0; t < 2; t++) begin
            c_in_valid = 1'b1;
            c_in_data  = tx_v[t];
            lsb_first  = (t == 1);
            @(posedge clk);
            #1;
            c_in_valid = 1'b0;
            c_sin      = rx_v[t];
            #1;
            checks++;
            if (c_sout !== tx_v[t] || c_sout_valid !== 1'b1 || c_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL full_width beat %0d: got sout=%h sv=%b ov=%b expected %h 1 0", t, c_sout, c_sout_valid, c_out_valid, tx_v[t]);
            end
            @(posedge clk);
            #2;
            checks++;
            if (c_out_valid !== 1'b1 || c_out_data !== rx_v[t] || c_sout !== 4'h0) begin
                errors++;
                $display("FAIL full_width result %0d: got ov=%b data=%h sout=%h expected 1 %h 0", t, c_out_valid, c_out_data, c_sout, rx_v[t]);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

`ifdef SERDES_LOOPBACK_EN
    task automatic test_loopback();
        for (int t = 0; t < 2; t++) begin
            d_in_valid = 1'b1;
            d_in_data  = 16'hBEEF;
            lsb_first  = (t == 1);
            @(posedge clk);
            #1;
            d_in_valid = 1'b0;
            for (int k = 0; k < 4; k++) @(posedge clk);
            #2;
            checks++;
            if (d_out_valid !== 1'b1 || d_out_data !== 16'hBEEF) begin
                errors++;
                $display("FAIL loopback order %0d: got ov=%b data=%h expected 1 beef", t, d_out_valid, d_out_data);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask
`endif

    initial begin
        test_reset();
        @(posedge clk);
        #1;
        test_msb_first();
        test_lsb_first();
        test_two_lanes();
        test_stall();
        test_back_to_back();
        test_reset_abort();
        test_full_width();
`ifdef SERDES_LOOPBACK_EN
        test_loopback();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
